// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// The unit runs a radix-2 shift-add multiply or a restoring divide, one bit per cycle.
// MULDIV_STALL holds the front of the pipeline until the result is ready.
module ex_muldiv_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32  // must equal XLEN: one result bit per iteration
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            BUSYWAIT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic [4:0]      ALU_OP,
    output logic [XLEN-1:0] RESULT,
    output logic            RESULT_VALID,
    output logic            MULDIV_STALL
);

    localparam int unsigned CW = $clog2(ITER) + 1;
    localparam logic [CW-1:0] LastIter = CW'(ITER - 1);

    typedef enum logic [1:0] {StIdle, StMulBusy, StDivBusy, StDone} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_counter;
    logic [2*XLEN-1:0] r_acc;     // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]   r_opnd;    // multiplicand or divisor magnitude
    logic              r_neg;     // negate the final magnitude
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_result;
    logic              r_valid;

    logic              w_is_m;
    logic [2:0]        w_funct3;
    logic              w_is_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_neg;
    logic              w_div_zero;
    logic              w_overflow;
    logic              w_special;
    logic [XLEN-1:0]   w_special_result;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_lo_fix;
    logic [XLEN-1:0]   w_hi_fix;
    logic [XLEN-1:0]   w_final;

    assign w_is_m   = (ALU_OP[4:3] == 2'b01);
    assign w_funct3 = ALU_OP[2:0];
    assign w_is_div = w_funct3[2];

    // Decode operand signedness and the magnitude/sign split for the op in ID/EX
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        unique case (w_funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            3'b010:  w_a_signed = 1'b1;
            default: ;
        endcase
        w_abs_a = (w_a_signed && DATA1[XLEN-1]) ? -DATA1 : DATA1;
        w_abs_b = (w_b_signed && DATA2[XLEN-1]) ? -DATA2 : DATA2;
        // Remainder follows the dividend; everything else follows the operand sign xor
        if (w_funct3 == 3'b110) begin
            w_neg = DATA1[XLEN-1];
        end else if (w_funct3 == 3'b111) begin
            w_neg = 1'b0;
        end else begin
            w_neg = (w_a_signed & DATA1[XLEN-1]) ^ (w_b_signed & DATA2[XLEN-1]);
        end
    end

    // Divide-by-zero and signed overflow skip the iterations entirely
    always_comb begin
        w_div_zero = (DATA2 == '0);
        w_overflow = w_is_div && !w_funct3[0] && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (DATA2 == '1);
        w_special  = w_is_div && (w_div_zero || w_overflow);
        if (w_div_zero) begin
            w_special_result = w_funct3[1] ? DATA1 : '1;
        end else begin
            w_special_result = w_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration of shift-add multiply or restoring divide, plus final sign fix
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
        w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
        w_div_shift = r_acc[2*XLEN-1:XLEN-1];
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        if (w_div_diff[XLEN]) begin
            w_div_next = {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end else begin
            w_div_next = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end
        w_acc_next = (r_state == StDivBusy) ? w_div_next : w_mul_next;
        w_prod     = r_neg ? -w_acc_next : w_acc_next;
        w_lo_fix   = r_neg ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
        w_hi_fix   = r_neg ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
        unique case (r_op)
            3'b000:                 w_final = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_lo_fix;
            default:                w_final = w_hi_fix;
        endcase
    end

    // Control FSM with datapath registers and registered result
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= StIdle;
            r_counter <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_neg     <= 1'b0;
            r_op      <= '0;
            r_result  <= '0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_is_m) begin
                        if (w_special) begin
                            r_result <= w_special_result;
                            r_valid  <= 1'b1;
                            r_state  <= StDone;
                        end else begin
                            r_opnd    <= w_is_div ? w_abs_b : w_abs_a;
                            r_acc     <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                            r_neg     <= w_neg;
                            r_op      <= w_funct3;
                            r_counter <= '0;
                            r_state   <= w_is_div ? StDivBusy : StMulBusy;
                        end
                    end
                end
                StMulBusy, StDivBusy: begin
                    r_acc     <= w_acc_next;
                    r_counter <= r_counter + 1'b1;
                    if (r_counter == LastIter) begin
                        r_result <= w_final;
                        r_valid  <= 1'b1;
                        r_state  <= StDone;
                    end
                end
                StDone: begin
                    if (!BUSYWAIT) begin
                        r_valid <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Stall is combinational in IDLE so the M op is frozen in ID/EX on its first cycle
    assign MULDIV_STALL = !RESET && ((r_state == StIdle && w_is_m) ||
                                     r_state == StMulBusy || r_state == StDivBusy);
    assign RESULT       = r_result;
    assign RESULT_VALID = r_valid;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic RV32M reference model.
module tb_ex_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BUSYWAIT;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [4:0]  ALU_OP;
    logic [31:0] RESULT;
    logic        RESULT_VALID;
    logic        MULDIV_STALL;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .BUSYWAIT     (BUSYWAIT),
        .DATA1        (DATA1),
        .DATA2        (DATA2),
        .ALU_OP       (ALU_OP),
        .RESULT       (RESULT),
        .RESULT_VALID (RESULT_VALID),
        .MULDIV_STALL (MULDIV_STALL)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RV32M semantics computed directly with wide arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        int          sa;
        int          sb;
        sa = a;
        sb = b;
        case (f)
            3'b000: return a * b;
            3'b001: begin
                ea = {{32{a[31]}}, a};
                eb = {{32{b[31]}}, b};
                p  = ea * eb;
                return p[63:32];
            end
            3'b010: begin
                ea = {{32{a[31]}}, a};
                eb = {32'd0, b};
                p  = ea * eb;
                return p[63:32];
            end
            3'b011: begin
                ea = {32'd0, a};
                eb = {32'd0, b};
                p  = ea * eb;
                return p[63:32];
            end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_stall(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 40)) - 32'd20;
            2: case ($urandom_range(0, 4))
                0: return 32'h0000_0000;
                1: return 32'h0000_0001;
                2: return 32'hFFFF_FFFF;
                3: return 32'h8000_0000;
                default: return 32'h7FFF_FFFF;
            endcase
            default: return 32'($urandom_range(0, 255));
        endcase
    endfunction

    // Present one M op (entered at posedge+1 with the unit idle), count stall cycles,
    // check the DONE cycle, optionally hold DONE with BUSYWAIT, then retire to IDLE.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int bw, input bit rand_bw);
        logic [31:0] exp;
        int          n;
        bit          done;
        exp    = model(f, a, b);
        ALU_OP = {2'b01, f};
        DATA1  = a;
        DATA2  = b;
        n      = 0;
        done   = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge CLK);
            if (MULDIV_STALL) begin
                n++;
                if (rand_bw) BUSYWAIT = 1'($urandom_range(0, 1));
                @(posedge CLK);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        check_eq({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall(f, a, b)));
        check_eq({tag, "_valid"}, {31'd0, RESULT_VALID}, 32'd1);
        check_eq({tag, "_result"}, RESULT, exp);
        BUSYWAIT = (bw > 0);
        for (int i = 0; i < bw; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check_eq({tag, "_bw_valid"}, {31'd0, RESULT_VALID}, 32'd1);
            check_eq({tag, "_bw_result"}, RESULT, exp);
            check_eq({tag, "_bw_stall"}, {31'd0, MULDIV_STALL}, 32'd0);
        end
        BUSYWAIT = 1'b0;
        @(posedge CLK);
        #1;
        ALU_OP = 5'b00000;
        @(negedge CLK);
        check_eq({tag, "_idle_valid"}, {31'd0, RESULT_VALID}, 32'd0);
        check_eq({tag, "_idle_stall"}, {31'd0, MULDIV_STALL}, 32'd0);
        check_eq({tag, "_idle_hold"}, RESULT, exp);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [4:0] op;
        logic [2:0] f;
        logic [31:0] a;
        logic [31:0] b;
        RESET    = 1'b1;
        BUSYWAIT = 1'b0;
        ALU_OP   = 5'b00000;
        DATA1    = '0;
        DATA2    = '0;
        #2;
        check_eq("rst_result", RESULT, 32'd0);
        check_eq("rst_valid", {31'd0, RESULT_VALID}, 32'd0);
        check_eq("rst_stall", {31'd0, MULDIV_STALL}, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        run_op("mul_signed", 3'b000, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
        run_op("mulhu_ones", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("mulh_ones", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("div_neg7", 3'b100, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op("rem_neg7", 3'b110, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op("divu_zero", 3'b101, 32'd123, 32'd0, 0, 1'b0);
        run_op("remu_zero", 3'b111, 32'd123, 32'd0, 0, 1'b0);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("bw_hold", 3'b000, 32'd1000, 32'd3000, 3, 1'b0);

        // Non-M ops never stall
        for (int i = 0; i < 12; i++) begin
            op = 5'($urandom);
            if (op[4:3] == 2'b01) op[4] = 1'b1;
            if (i == 0) op = 5'b00000;
            ALU_OP = op;
            DATA1  = $urandom;
            DATA2  = $urandom;
            @(negedge CLK);
            check_eq("nonm_stall", {31'd0, MULDIV_STALL}, 32'd0);
            check_eq("nonm_valid", {31'd0, RESULT_VALID}, 32'd0);
            @(posedge CLK);
            #1;
        end

        // Reset in the middle of a multiply abandons it
        ALU_OP = 5'b01000;
        DATA1  = 32'd7;
        DATA2  = 32'hFFFF_FFFD;
        repeat (10) begin
            @(posedge CLK);
        end
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check_eq("midrst_result", RESULT, 32'd0);
        check_eq("midrst_valid", {31'd0, RESULT_VALID}, 32'd0);
        check_eq("midrst_stall", {31'd0, MULDIV_STALL}, 32'd0);
        ALU_OP = 5'b00000;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check_eq("postrst_stall", {31'd0, MULDIV_STALL}, 32'd0);
            check_eq("postrst_valid", {31'd0, RESULT_VALID}, 32'd0);
            check_eq("postrst_result", RESULT, 32'd0);
        end
        @(posedge CLK);
        #1;
        run_op("after_rst", 3'b000, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);

        // Randomized ops, with BUSYWAIT wiggling during iteration and in DONE
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op("rand", f, a, b, int'($urandom_range(0, 2)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
